// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults, well-known register indices and the index type for the
// register file and its busy scoreboard.
package regfile_scoreboard_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = reg_idx_t'(0);
    localparam reg_idx_t REG_RA   = reg_idx_t'(31);

endpackage

// File: rtl/regfile_scoreboard_busy.sv
// Per-register busy scoreboard with a pending-producer counter that tracks
// the popcount of the busy vector.
module regfile_scoreboard_busy
    import regfile_scoreboard_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              set_valid,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_valid,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] look_a_idx,
    output logic              look_a_busy,
    input  logic [ADDR_W-1:0] look_b_idx,
    output logic              look_b_busy,
    input  logic [ADDR_W-1:0] look_w_idx,
    output logic              look_w_busy,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W:0] CNT_MAX = CNT_W'(NUM_REGS);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                inc;
    logic                dec;

    // Set is applied after clear so a new producer wins over a retiring one.
    always_comb begin
        busy_next = busy;
        if (clr_valid) busy_next[clr_idx] = 1'b0;
        if (set_valid) busy_next[set_idx] = 1'b1;
    end

    assign inc = set_valid && !busy[set_idx];
    assign dec = clr_valid && busy[clr_idx] && !(set_valid && (set_idx == clr_idx));

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy <= busy_next;
            if (inc && !dec && (pending_cnt != CNT_MAX))
                pending_cnt <= pending_cnt + CNT_W'(1);
            else if (dec && !inc && (pending_cnt != '0))
                pending_cnt <= pending_cnt - CNT_W'(1);
        end
    end

    assign look_a_busy = busy[look_a_idx];
    assign look_b_busy = busy[look_b_idx];
    assign look_w_busy = busy[look_w_idx];

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with optional writeback bypass and a busy
// scoreboard used by decode for RAW/WAW stall detection.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] outA,
    output logic [DATA_W-1:0] outB,
    output logic              busyA,
    output logic              busyB,
    input  logic              RegWre,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] writeData,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    output logic              stall,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic rd_is_zero;
    logic wb_hit_a;
    logic wb_hit_b;
    logic wb_hit_w;
    logic fwd_a;
    logic fwd_b;
    logic sb_busy_a;
    logic sb_busy_b;
    logic sb_busy_w;
    logic issue_accept;

    assign rd_is_zero = (ZERO_REG != 0) && (rd == '0);

    assign wb_hit_a = RegWre && (rd == rs);
    assign wb_hit_b = RegWre && (rd == rt);
    assign wb_hit_w = RegWre && (rd == issue_rd);

    assign fwd_a = (BYPASS != 0) && wb_hit_a && !rd_is_zero;
    assign fwd_b = (BYPASS != 0) && wb_hit_b && !rd_is_zero;

    always_comb begin
        outA = regs[rs];
        if (fwd_a) outA = writeData;
        if ((ZERO_REG != 0) && (rs == '0)) outA = '0;
    end

    always_comb begin
        outB = regs[rt];
        if (fwd_b) outB = writeData;
        if ((ZERO_REG != 0) && (rt == '0)) outB = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (RegWre && !rd_is_zero) begin
            regs[rd] <= writeData;
        end
    end

    // A producer retiring this cycle only resolves a read hazard when its data is forwarded.
    assign busyA = sb_busy_a && !((BYPASS != 0) && wb_hit_a);
    assign busyB = sb_busy_b && !((BYPASS != 0) && wb_hit_b);

    assign issue_ready  = !sb_busy_w || wb_hit_w;
    assign stall        = issue_valid && (busyA || busyB || !issue_ready);
    assign issue_accept = issue_valid && issue_ready && !stall &&
                          !((ZERO_REG != 0) && (issue_rd == '0));

    regfile_scoreboard_busy #(
        .ADDR_W (ADDR_W)
    ) u_busy (
        .CLK         (CLK),
        .RST         (RST),
        .set_valid   (issue_accept),
        .set_idx     (issue_rd),
        .clr_valid   (RegWre),
        .clr_idx     (rd),
        .look_a_idx  (rs),
        .look_a_busy (sb_busy_a),
        .look_b_idx  (rt),
        .look_b_busy (sb_busy_b),
        .look_w_idx  (issue_rd),
        .look_w_busy (sb_busy_w),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector bench for regfile_scoreboard: a BYPASS=1 and a BYPASS=0
// instance share stimulus; a small busy model cross-checks pending_cnt.
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    logic        CLK;
    logic        RST;
    logic [4:0]  rs, rt, rd, issue_rd;
    logic [31:0] writeData;
    logic        RegWre, issue_valid;

    logic [31:0] outA, outB;
    logic        busyA, busyB, issue_ready, stall;
    logic [5:0]  pending_cnt;

    logic [31:0] nb_outA, nb_outB;
    logic        nb_busyA, nb_busyB, nb_ready, nb_stall;
    logic [5:0]  nb_pending;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_busy;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .CLK(CLK), .RST(RST), .rs(rs), .rt(rt), .outA(outA), .outB(outB),
        .busyA(busyA), .busyB(busyB), .RegWre(RegWre), .rd(rd), .writeData(writeData),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .stall(stall), .pending_cnt(pending_cnt)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) u_nb (
        .CLK(CLK), .RST(RST), .rs(rs), .rt(rt), .outA(nb_outA), .outB(nb_outB),
        .busyA(nb_busyA), .busyB(nb_busyB), .RegWre(RegWre), .rd(rd), .writeData(writeData),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(nb_ready),
        .stall(nb_stall), .pending_cnt(nb_pending)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst, we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ird, rs, rt;
        logic [31:0] oa, ob;
        logic        ba, bb, rdy, stl;
        logic [5:0]  pc;
        logic [31:0] nb_oa;
        logic        nb_ba;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic we, input logic [4:0] rd_i, input logic [31:0] wd,
        input logic iv, input logic [4:0] ird, input logic [4:0] rs_i, input logic [4:0] rt_i,
        input logic [31:0] oa, input logic [31:0] ob, input logic ba, input logic bb,
        input logic rdy, input logic stl, input logic [5:0] pc,
        input logic [31:0] nb_oa, input logic nb_ba);
        vec_t v;
        v.rst = rst; v.we = we; v.rd = rd_i; v.wd = wd; v.iv = iv; v.ird = ird;
        v.rs = rs_i; v.rt = rt_i; v.oa = oa; v.ob = ob; v.ba = ba; v.bb = bb;
        v.rdy = rdy; v.stl = stl; v.pc = pc; v.nb_oa = nb_oa; v.nb_ba = nb_ba;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int row);
        logic m_stall, m_acc;
        RST = v.rst; RegWre = v.we; rd = v.rd; writeData = v.wd;
        issue_valid = v.iv; issue_rd = v.ird; rs = v.rs; rt = v.rt;
        #4;
        chk("outA",        row, outA,               v.oa);
        chk("outB",        row, outB,               v.ob);
        chk("busyA",       row, {31'b0, busyA},     {31'b0, v.ba});
        chk("busyB",       row, {31'b0, busyB},     {31'b0, v.bb});
        chk("issue_ready", row, {31'b0, issue_ready}, {31'b0, v.rdy});
        chk("stall",       row, {31'b0, stall},     {31'b0, v.stl});
        chk("pending_cnt", row, {26'b0, pending_cnt}, {26'b0, v.pc});
        chk("nb_outA",     row, nb_outA,            v.nb_oa);
        chk("nb_busyA",    row, {31'b0, nb_busyA},  {31'b0, v.nb_ba});
        chk("popcount",    row, {26'b0, pending_cnt}, 32'($countones(m_busy)));
        m_stall = v.iv && ((m_busy[v.rs] && !(v.we && v.rd == v.rs)) ||
                           (m_busy[v.rt] && !(v.we && v.rd == v.rt)) ||
                           (m_busy[v.ird] && !(v.we && v.rd == v.ird)));
        m_acc = v.iv && !m_stall && (v.ird != REG_ZERO);
        @(posedge CLK);
        if (v.rst) m_busy = '0;
        else begin
            if (v.we) m_busy[v.rd] = 1'b0;
            if (m_acc) m_busy[v.ird] = 1'b1;
        end
        #1;
    endtask

    vec_t tbl [29];

    initial begin
        //              rst we rd  wd            iv ird rs  rt   oa            ob            ba bb rdy stl pc nb_oa         nb_ba
        tbl[0]  = mk(0, 0, 0,  32'h0,        0, 0,  5,  31, 32'h0,        32'h0,        0, 0, 1, 0, 0, 32'h0,        0);
        tbl[1]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        0, 0, 1, 0, 0, 32'h0,        0);
        tbl[2]  = mk(0, 0, 0,  32'h0,        0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 0, 0, 32'hDEADBEEF, 0);
        tbl[3]  = mk(1, 1, 5,  32'h11111111, 1, 4,  5,  4,  32'h11111111, 32'h0,        0, 0, 1, 0, 0, 32'hDEADBEEF, 0);
        tbl[4]  = mk(0, 0, 0,  32'h0,        0, 4,  5,  4,  32'h0,        32'h0,        0, 0, 1, 0, 0, 32'h0,        0);
        tbl[5]  = mk(0, 1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  32'h0,        32'h0,        0, 0, 1, 0, 0, 32'h0,        0);
        tbl[6]  = mk(0, 0, 0,  32'h0,        0, 0,  0,  5,  32'h0,        32'h0,        0, 0, 1, 0, 0, 32'h0,        0);
        tbl[7]  = mk(0, 0, 0,  32'h0,        1, 3,  1,  2,  32'h0,        32'h0,        0, 0, 1, 0, 0, 32'h0,        0);
        tbl[8]  = mk(0, 0, 0,  32'h0,        1, 8,  3,  0,  32'h0,        32'h0,        1, 0, 1, 1, 1, 32'h0,        1);
        tbl[9]  = mk(0, 1, 3,  32'h55,       1, 8,  3,  3,  32'h55,       32'h55,       0, 0, 1, 0, 1, 32'h0,        1);
        tbl[10] = mk(0, 0, 0,  32'h0,        0, 8,  3,  8,  32'h55,       32'h0,        0, 1, 0, 0, 1, 32'h55,       0);
        tbl[11] = mk(0, 1, 8,  32'hA5A5,     0, 8,  8,  3,  32'hA5A5,     32'h55,       0, 0, 1, 0, 1, 32'h0,        0);
        tbl[12] = mk(0, 0, 0,  32'h0,        1, 9,  0,  0,  32'h0,        32'h0,        0, 0, 1, 0, 0, 32'h0,        0);
        tbl[13] = mk(0, 1, 9,  32'h99,       1, 9,  0,  0,  32'h0,        32'h0,        0, 0, 1, 0, 1, 32'h0,        0);
        tbl[14] = mk(0, 0, 0,  32'h0,        0, 9,  9,  0,  32'h99,       32'h0,        1, 0, 0, 0, 1, 32'h99,       1);
        tbl[15] = mk(0, 0, 0,  32'h0,        1, 9,  0,  0,  32'h0,        32'h0,        0, 0, 0, 1, 1, 32'h0,        0);
        tbl[16] = mk(0, 1, 9,  32'h77,       0, 9,  9,  0,  32'h77,       32'h0,        0, 0, 1, 0, 1, 32'h99,       1);
        tbl[17] = mk(0, 0, 0,  32'h0,        1, 1,  9,  0,  32'h77,       32'h0,        0, 0, 1, 0, 0, 32'h77,       0);
        tbl[18] = mk(0, 0, 0,  32'h0,        1, 2,  0,  0,  32'h0,        32'h0,        0, 0, 1, 0, 1, 32'h0,        0);
        tbl[19] = mk(0, 0, 0,  32'h0,        1, 3,  0,  0,  32'h0,        32'h0,        0, 0, 1, 0, 2, 32'h0,        0);
        tbl[20] = mk(0, 0, 0,  32'h0,        0, 0,  1,  2,  32'h0,        32'h0,        1, 1, 1, 0, 3, 32'h0,        1);
        tbl[21] = mk(0, 1, 1,  32'h10,       0, 0,  1,  2,  32'h10,       32'h0,        0, 1, 1, 0, 3, 32'h0,        1);
        tbl[22] = mk(0, 1, 2,  32'h20,       0, 0,  1,  2,  32'h10,       32'h20,       0, 0, 1, 0, 2, 32'h10,       0);
        tbl[23] = mk(0, 1, 3,  32'h30,       0, 0,  3,  3,  32'h30,       32'h30,       0, 0, 1, 0, 1, 32'h55,       1);
        tbl[24] = mk(0, 0, 0,  32'h0,        0, 0,  2,  3,  32'h20,       32'h30,       0, 0, 1, 0, 0, 32'h20,       0);
        tbl[25] = mk(0, 0, 0,  32'h0,        1, 10, 0,  0,  32'h0,        32'h0,        0, 0, 1, 0, 0, 32'h0,        0);
        tbl[26] = mk(0, 0, 0,  32'h0,        1, 11, 0,  0,  32'h0,        32'h0,        0, 0, 1, 0, 1, 32'h0,        0);
        tbl[27] = mk(1, 0, 0,  32'h0,        1, 12, 0,  0,  32'h0,        32'h0,        0, 0, 1, 0, 2, 32'h0,        0);
        tbl[28] = mk(0, 0, 0,  32'h0,        0, 12, 10, 11, 32'h0,        32'h0,        0, 0, 1, 0, 0, 32'h0,        0);

        m_busy = '0;
        RST = 1'b1; RegWre = 1'b0; rd = '0; writeData = '0;
        issue_valid = 1'b0; issue_rd = '0; rs = '0; rt = '0;
        @(posedge CLK);
        @(posedge CLK);
        #1;

        for (int i = 0; i < 29; i++)
            run_vec(tbl[i], i);

        // Return-address register: forwarded on rt in BYPASS=1, stale in BYPASS=0.
        run_vec(mk(0, 0, 0,      32'h0,        1, REG_RA, 0,      REG_RA, 32'h0,        32'h0,        0, 0, 1, 0, 0, 32'h0,        0), 100);
        run_vec(mk(0, 1, REG_RA, 32'hCAFEF00D, 0, REG_RA, REG_RA, REG_RA, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 1, 0, 1, 32'h0,        1), 101);
        run_vec(mk(0, 0, 0,      32'h0,        0, REG_RA, REG_RA, 0,      32'hCAFEF00D, 32'h0,        0, 0, 1, 0, 0, 32'hCAFEF00D, 0), 102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
